// File: rtl/pipe_in_verify.sv
// Pipe In checker: verifies the host write stream against the Count/LFSR pattern and models
// a throttled virtual receive FIFO for pipe_in_ready. Optional first-mismatch capture: PIPE_IN_VERIFY_CAPTURE_EN.
module pipe_in_verify #(
   parameter int DEPTH      = 65535,
   parameter int READY_ROOM = 1024,
   parameter int ERR_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pipe_in_write,
   input  logic [15:0]      pipe_in_data,
   output logic             pipe_in_ready,
   input  logic             throttle_set,
   input  logic [31:0]      throttle_val,
   input  logic             mode,
   output logic [ERR_W-1:0] error_count,
   output logic [31:0]      word_count,
   output logic             overflow,
   output logic [31:0]      first_err_idx,
   output logic [15:0]      first_err_exp,
   output logic [15:0]      first_err_got
);

   localparam logic [15:0] DEPTH_L    = 16'(DEPTH);
   localparam logic [15:0] ROOM_L     = 16'(READY_ROOM);
   localparam logic [63:0] SEED_COUNT = 64'h0000000100000001;
   localparam logic [63:0] SEED_LFSR  = 64'h0D0C0B0A04030201;

   logic        mode_q;
   logic [63:0] exp, exp_nxt;
   logic [15:0] level;
   logic [31:0] throttle;
   logic        mismatch;

   function automatic logic [31:0] lfsr_step(input logic [31:0] t);
      return {t[30:0], t[31] ^ t[21] ^ t[1]};
   endfunction

   assign mismatch = pipe_in_write && (pipe_in_data != exp[15:0]);

   // Both 32-bit halves advance together so the stream matches the Pipe Out read order.
   always_comb begin
      exp_nxt = exp;
      if (mode_q) exp_nxt = {lfsr_step(exp[63:32]), lfsr_step(exp[31:0])};
      else        exp_nxt = {exp[63:32] + 32'd1, exp[31:0] + 32'd1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_in_ready <= 1'b0;
         error_count   <= '0;
         word_count    <= '0;
         overflow      <= 1'b0;
         level         <= '0;
         throttle      <= throttle_val;
         mode_q        <= mode;
         exp           <= mode ? SEED_LFSR : SEED_COUNT;
      end else begin
         // Ready looks at the level before this cycle's write/drain.
         pipe_in_ready <= (DEPTH_L - level) >= ROOM_L;
         throttle      <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
         if (pipe_in_write) begin
            word_count <= word_count + 32'd1;
            exp        <= exp_nxt;
            if (mismatch && (error_count != '1))
               error_count <= error_count + ERR_W'(1);
         end
         case ({pipe_in_write, throttle[0]})
            2'b10: begin
               if (level == DEPTH_L) overflow <= 1'b1;
               else                  level    <= level + 16'd1;
            end
            2'b01: if (level != 16'd0) level <= level - 16'd1;
            default: ;
         endcase
      end
   end

`ifdef PIPE_IN_VERIFY_CAPTURE_EN
   logic err_seen;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_seen      <= 1'b0;
         first_err_idx <= '0;
         first_err_exp <= '0;
         first_err_got <= '0;
      end else if (mismatch && !err_seen) begin
         err_seen      <= 1'b1;
         first_err_idx <= word_count;
         first_err_exp <= exp[15:0];
         first_err_got <= pipe_in_data;
      end
   end
`else
   assign first_err_idx = '0;
   assign first_err_exp = '0;
   assign first_err_got = '0;
`endif

endmodule

// File: tb/tb_pipe_in_verify.sv
// Scoreboard bench for pipe_in_verify: a per-cycle reference model pushes expected outputs,
// which are popped and compared after each clock edge, plus fixed-value spot checks.
module tb_pipe_in_verify;

   localparam int DEPTH      = 300;
   localparam int READY_ROOM = 32;
   localparam int ERR_W      = 4;
   localparam int ERR_MAX    = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             pipe_in_write = 1'b0;
   logic [15:0]      pipe_in_data = '0;
   logic             pipe_in_ready;
   logic             throttle_set = 1'b0;
   logic [31:0]      throttle_val = '0;
   logic             mode = 1'b0;
   logic [ERR_W-1:0] error_count;
   logic [31:0]      word_count;
   logic             overflow;
   logic [31:0]      first_err_idx;
   logic [15:0]      first_err_exp;
   logic [15:0]      first_err_got;

   pipe_in_verify #(.DEPTH(DEPTH), .READY_ROOM(READY_ROOM), .ERR_W(ERR_W)) dut (
      .clk(clk), .reset(reset),
      .pipe_in_write(pipe_in_write), .pipe_in_data(pipe_in_data), .pipe_in_ready(pipe_in_ready),
      .throttle_set(throttle_set), .throttle_val(throttle_val), .mode(mode),
      .error_count(error_count), .word_count(word_count), .overflow(overflow),
      .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic [31:0] wc;
      int          err;
      logic        ovf;
      logic [31:0] fidx;
      logic [15:0] fexp;
      logic [15:0] fgot;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_fail = 0;

   // reference model state
   logic [63:0] m_exp;
   logic        m_mode, m_rdy, m_ovf, m_seen;
   logic [31:0] m_wc, m_thr, m_fidx;
   logic [15:0] m_fexp, m_fgot;
   int          m_err, m_lvl;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] lfsr(input logic [31:0] t);
      return {t[30:0], t[31] ^ t[21] ^ t[1]};
   endfunction

   task automatic cyc(input logic r, input logic md, input logic w, input logic [15:0] d,
                      input logic ts, input logic [31:0] tv);
      exp_t e;
      logic drain;
      reset = r; mode = md; pipe_in_write = w; pipe_in_data = d;
      throttle_set = ts; throttle_val = tv;
      if (r) begin
         m_rdy = 0; m_wc = 0; m_err = 0; m_ovf = 0; m_lvl = 0; m_thr = tv; m_mode = md;
         m_exp = md ? 64'h0D0C0B0A04030201 : 64'h0000000100000001;
         m_seen = 0; m_fidx = 0; m_fexp = 0; m_fgot = 0;
      end else begin
         drain = m_thr[0];
         m_rdy = (DEPTH - m_lvl) >= READY_ROOM;
         if (w) begin
            if (d != m_exp[15:0]) begin
`ifdef PIPE_IN_VERIFY_CAPTURE_EN
               if (!m_seen) begin
                  m_seen = 1; m_fidx = m_wc; m_fexp = m_exp[15:0]; m_fgot = d;
               end
`endif
               if (m_err != ERR_MAX) m_err++;
            end
            m_wc++;
            m_exp = m_mode ? {lfsr(m_exp[63:32]), lfsr(m_exp[31:0])}
                           : {m_exp[63:32] + 32'd1, m_exp[31:0] + 32'd1};
         end
         if (w && !drain) begin
            if (m_lvl == DEPTH) m_ovf = 1;
            else m_lvl++;
         end else if (!w && drain && m_lvl > 0) m_lvl--;
         m_thr = ts ? tv : {m_thr[0], m_thr[31:1]};
      end
      e.rdy = m_rdy; e.wc = m_wc; e.err = m_err; e.ovf = m_ovf;
      e.fidx = m_fidx; e.fexp = m_fexp; e.fgot = m_fgot;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("ready", 32'(pipe_in_ready), 32'(e.rdy));
      chk("word_count", word_count, e.wc);
      chk("error_count", 32'(error_count), 32'(e.err));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("first_err_idx", first_err_idx, e.fidx);
      chk("first_err_exp", 32'(first_err_exp), 32'(e.fexp));
      chk("first_err_got", 32'(first_err_got), 32'(e.fgot));
   endtask

   task automatic rst(input logic md, input logic [31:0] tv);
      cyc(1, md, 0, 16'h0, 0, tv);
   endtask
   task automatic wr(input logic [15:0] d);
      cyc(0, 0, 1, d, 0, 32'h0);
   endtask
   task automatic idle();
      cyc(0, 0, 0, 16'h0, 0, 32'h0);
   endtask
   task automatic wr_ref(input int n);
      for (int i = 0; i < n; i++) wr(m_exp[15:0]);
   endtask

   initial begin
      logic [15:0] bad_ref;
      bad_ref = '0;

      // 1. count mode: words 1..16 check clean
      rst(0, 32'h0);
      chk("rst_ready", 32'(pipe_in_ready), 32'h0);
      chk("rst_wc", word_count, 32'h0);
      for (int i = 1; i <= 16; i++) wr(16'(i));
      chk("count_err", 32'(error_count), 32'h0);
      chk("count_wc", word_count, 32'd16);

      // 2. LFSR stream, then a corrupted run
      rst(1, 32'h0);
      wr_ref(4096);
      chk("lfsr_err", 32'(error_count), 32'h0);
      chk("lfsr_wc", word_count, 32'd4096);
      rst(1, 32'h0);
      for (int i = 0; i < 150; i++) begin
         if (i == 100) bad_ref = m_exp[15:0];
         if (i == 100 || i == 120) wr(m_exp[15:0] ^ 16'h0001);
         else wr(m_exp[15:0]);
         if (i == 110) begin
            chk("corrupt_err", 32'(error_count), 32'd1);
`ifdef PIPE_IN_VERIFY_CAPTURE_EN
            chk("cap_idx", first_err_idx, 32'd100);
            chk("cap_exp", 32'(first_err_exp), 32'(bad_ref));
            chk("cap_got", 32'(first_err_got), 32'(bad_ref ^ 16'h0001));
`endif
         end
      end
      chk("corrupt_err2", 32'(error_count), 32'd2);
`ifdef PIPE_IN_VERIFY_CAPTURE_EN
      chk("cap_keep", first_err_idx, 32'd100);
`else
      chk("cap_off", first_err_idx, 32'd0);
`endif

      // 3. throttle and ready threshold (room >= 32 <=> level <= 268)
      rst(0, 32'h0);
      idle();
      chk("ready_after_rst", 32'(pipe_in_ready), 32'h1);
      wr_ref(269);
      chk("ready_at_269", 32'(pipe_in_ready), 32'h1);
      idle();
      chk("ready_full", 32'(pipe_in_ready), 32'h0);
      cyc(0, 0, 0, 16'h0, 1, 32'hFFFF_FFFF);
      chk("ready_tset", 32'(pipe_in_ready), 32'h0);
      idle();
      chk("ready_drain1", 32'(pipe_in_ready), 32'h0);
      idle();
      chk("ready_back", 32'(pipe_in_ready), 32'h1);

      // 4. overflow at DEPTH+1 writes
      rst(0, 32'h0);
      wr_ref(DEPTH);
      chk("no_ovf", 32'(overflow), 32'h0);
      wr_ref(1);
      chk("ovf", 32'(overflow), 32'h1);
      chk("ovf_wc", word_count, 32'(DEPTH + 1));
      idle();
      chk("ovf_sticky", 32'(overflow), 32'h1);

      // 5. write + drain every cycle holds level; error saturation
      rst(0, 32'hFFFF_FFFF);
      wr_ref(400);
      chk("simul_ovf", 32'(overflow), 32'h0);
      chk("simul_ready", 32'(pipe_in_ready), 32'h1);
      rst(0, 32'h0);
      for (int i = 0; i < 20; i++) wr(m_exp[15:0] ^ 16'h8000);
      chk("err_sat", 32'(error_count), 32'(ERR_MAX));

      // 6. reset mid-stream into LFSR mode
      rst(0, 32'h0);
      wr_ref(50);
      rst(1, 32'h0);
      chk("mid_wc", word_count, 32'h0);
      chk("mid_err", 32'(error_count), 32'h0);
      wr(16'h0201);
      wr(16'h0402);
      wr(16'h0805);
      chk("mid_lfsr_err", 32'(error_count), 32'h0);
      chk("mid_lfsr_wc", word_count, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
